// File: rtl/draw_cmd_arbiter_if.sv
// draw_cmd_arbiter_if: requester FIFOs, downstream draw-command port and status of draw_cmd_arbiter
interface draw_cmd_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int CMD_W = 36
);
  localparam int LW = $clog2(DEPTH + 1);
  logic a_valid, a_ready, a_lock;
  logic b_valid, b_ready, b_lock;
  logic draw_busy, draw_cmd_rdy;
  logic [CMD_W-1:0] a_cmd, b_cmd, draw_cmd;
  logic [1:0] grant;
  logic [LW-1:0] a_level, b_level;
  modport master (
    output a_valid, a_cmd, a_lock, b_valid, b_cmd, b_lock, draw_busy,
    input a_ready, b_ready, draw_cmd_rdy, draw_cmd, grant, a_level, b_level
  );
  modport slave (
    input a_valid, a_cmd, a_lock, b_valid, b_cmd, b_lock, draw_busy,
    output a_ready, b_ready, draw_cmd_rdy, draw_cmd, grant, a_level, b_level
  );
endinterface

// File: rtl/draw_cmd_arbiter.sv
// draw_cmd_arbiter: two-FIFO round-robin arbiter with grant locking feeding the pixel address generator
module draw_cmd_arbiter #(
  parameter int DEPTH = 4,
  parameter int CMD_W = 36
) (
  input logic clk,
  input logic reset_n,
  draw_cmd_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t state, state_nxt;
  logic [CMD_W-1:0] mem [2][DEPTH];
  logic [PW-1:0] wp [2];
  logic [PW-1:0] rp [2];
  logic [LW-1:0] cnt [2];
  logic [CMD_W-1:0] cmd [2];
  logic [1:0] valid, lock, ready, push, pop, elig;
  logic rr, slot_free, sel, take, nop, rdy_q;
  logic [CMD_W-1:0] head, cmd_q;
  logic [1:0] grant_q;
  assign valid = {bus.b_valid, bus.a_valid};
  assign lock = {bus.b_lock, bus.a_lock};
  assign cmd[0] = bus.a_cmd;
  assign cmd[1] = bus.b_cmd;
  assign bus.a_ready = ready[0];
  assign bus.b_ready = ready[1];
  assign bus.a_level = cnt[0];
  assign bus.b_level = cnt[1];
  assign bus.draw_cmd_rdy = rdy_q;
  assign bus.draw_cmd = cmd_q;
  assign bus.grant = grant_q;
  // FIFO flags, eligibility and round-robin pick; rr=1 means B is favoured next
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      ready[k] = cnt[k] != LW'(DEPTH);
      push[k] = valid[k] && ready[k];
    end
    slot_free = !rdy_q || !bus.draw_busy;
    elig[0] = cnt[0] != '0 && state != OWN_B;
    elig[1] = cnt[1] != '0 && state != OWN_A;
    sel = elig[1] && (!elig[0] || rr);
    take = slot_free && |elig;
    pop = take ? (sel ? 2'b10 : 2'b01) : 2'b00;
    head = mem[sel][rp[sel]];
    nop = head[CMD_W-1 -: 4] == 4'h0;
  end
  // lock ownership: taken by popping from a locking port in IDLE, released once unlocked and drained
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (pop[0] && lock[0] ? OWN_A : pop[1] && lock[1] ? OWN_B : IDLE)
              : state == OWN_A ? (!lock[0] && cnt[0] == '0 ? IDLE : OWN_A)
              : (!lock[1] && cnt[1] == '0 ? IDLE : OWN_B);
  end
  // FSM state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // FIFO storage; only slots between rp and wp are ever read, so no reset is needed
  always_ff @(posedge clk)
    for (int k = 0; k < 2; k++) if (push[k]) mem[k][wp[k]] <= cmd[k];
  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        wp[k] <= '0;
        rp[k] <= '0;
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        wp[k] <= wp[k] + PW'(push[k]);
        rp[k] <= rp[k] + PW'(pop[k]);
        cnt[k] <= cnt[k] + LW'(push[k]) - LW'(pop[k]);
      end
    end
  // output slot: loads the popped head unless it is a NOP; NOP pops still count as service
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rr <= 1'b0;
      rdy_q <= 1'b0;
      cmd_q <= '0;
      grant_q <= 2'b00;
    end else begin
      if (take) rr <= !sel;
      if (slot_free) rdy_q <= take && !nop;
      if (take && !nop) begin
        cmd_q <= head;
        grant_q <= sel ? 2'b10 : 2'b01;
      end
    end
endmodule

// File: tb/tb_draw_cmd_arbiter.sv
// tb_draw_cmd_arbiter: directed and random stimulus checked against a queue-based arbiter model
module tb_draw_cmd_arbiter;
  localparam int DEPTH = 4;
  localparam int CMD_W = 36;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  draw_cmd_arbiter_if #(.DEPTH(DEPTH), .CMD_W(CMD_W)) bus ();
  draw_cmd_arbiter #(.DEPTH(DEPTH), .CMD_W(CMD_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [CMD_W-1:0] qa [$];
  logic [CMD_W-1:0] qb [$];
  logic [CMD_W-1:0] got [$];
  logic [CMD_W-1:0] exp_q [$];
  int got_t [$];
  int owner, last;
  bit m_rdy;
  logic [CMD_W-1:0] m_cmd;
  logic [1:0] m_grant;

  task automatic chk(input string tag, input logic [63:0] seen, input logic [63:0] want);
    total++;
    if (seen !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, seen, want, cyc);
    end
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, got[i], exp_q[i]);
  endtask

  task automatic set_in(input bit av, input logic [CMD_W-1:0] ac, input bit al,
                        input bit bv, input logic [CMD_W-1:0] bc, input bit bl, input bit busy);
    bus.a_valid = av;
    bus.a_cmd = ac;
    bus.a_lock = al;
    bus.b_valid = bv;
    bus.b_cmd = bc;
    bus.b_lock = bl;
    bus.draw_busy = busy;
  endtask

  // one cycle of the reference: 1 = A, 2 = B; owner 0 means no lock held
  task automatic step;
    int na, nb, pick, nown;
    bit ra, rb, sf, ea, eb;
    logic [CMD_W-1:0] h;
    if (bus.draw_cmd_rdy && !bus.draw_busy) begin
      got.push_back(bus.draw_cmd);
      got_t.push_back(cyc);
    end
    na = qa.size();
    nb = qb.size();
    ra = na != DEPTH;
    rb = nb != DEPTH;
    chk("a_ready", 64'(bus.a_ready), 64'(ra));
    chk("b_ready", 64'(bus.b_ready), 64'(rb));
    sf = !m_rdy || !bus.draw_busy;
    ea = na > 0 && owner != 2;
    eb = nb > 0 && owner != 1;
    nown = owner;
    if (owner == 1 && !bus.a_lock && na == 0) nown = 0;
    if (owner == 2 && !bus.b_lock && nb == 0) nown = 0;
    if (sf && (ea || eb)) begin
      pick = (ea && eb) ? (last == 1 ? 2 : 1) : (ea ? 1 : 2);
      h = pick == 1 ? qa.pop_front() : qb.pop_front();
      last = pick;
      if (owner == 0 && (pick == 1 ? bus.a_lock : bus.b_lock)) nown = pick;
      m_rdy = h[CMD_W-1:CMD_W-4] != 4'h0;
      if (m_rdy) begin
        m_cmd = h;
        m_grant = pick == 1 ? 2'b01 : 2'b10;
      end
    end else if (sf) m_rdy = 1'b0;
    if (bus.a_valid && ra) qa.push_back(bus.a_cmd);
    if (bus.b_valid && rb) qb.push_back(bus.b_cmd);
    owner = nown;
  endtask

  task automatic tick;
    step();
    @(posedge clk);
    #1;
    cyc++;
    chk("draw_cmd_rdy", 64'(bus.draw_cmd_rdy), 64'(m_rdy));
    chk("draw_cmd", 64'(bus.draw_cmd), 64'(m_cmd));
    if (m_rdy) chk("grant", 64'(bus.grant), 64'(m_grant));
    chk("a_level", 64'(bus.a_level), 64'(qa.size()));
    chk("b_level", 64'(bus.b_level), 64'(qb.size()));
  endtask

  // asynchronous reset asserted between clock edges; outputs checked before any edge arrives
  task automatic do_reset;
    reset_n = 1'b0;
    set_in(0, '0, 0, 0, '0, 0, 0);
    #3;
    qa.delete();
    qb.delete();
    owner = 0;
    last = 2;
    m_rdy = 1'b0;
    m_cmd = '0;
    m_grant = 2'b00;
    chk("rst_rdy", 64'(bus.draw_cmd_rdy), 64'd0);
    chk("rst_cmd", 64'(bus.draw_cmd), 64'd0);
    chk("rst_grant", 64'(bus.grant), 64'd0);
    chk("rst_a_level", 64'(bus.a_level), 64'd0);
    chk("rst_b_level", 64'(bus.b_level), 64'd0);
    chk("rst_a_ready", 64'(bus.a_ready), 64'd1);
    chk("rst_b_ready", 64'(bus.b_ready), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    got.delete();
    got_t.delete();
    exp_q.delete();
  endtask

  initial begin
    int i;
    bit al, bl;
    do_reset();
    // single command latency
    set_in(1, 36'h1_0700_500A, 0, 0, '0, 0, 0);
    tick();
    set_in(0, '0, 0, 0, '0, 0, 0);
    chk("lat_c1_rdy", 64'(bus.draw_cmd_rdy), 64'd0);
    tick();
    chk("lat_c2_rdy", 64'(bus.draw_cmd_rdy), 64'd1);
    chk("lat_c2_cmd", 64'(bus.draw_cmd), 64'h1_0700_500A);
    chk("lat_c2_grant", 64'(bus.grant), 64'd1);
    tick();
    chk("lat_c3_rdy", 64'(bus.draw_cmd_rdy), 64'd0);
    chk("lat_n", 64'(got.size()), 64'd1);
    chk("lat_cycle", 64'(got_t.size() > 0 ? got_t[0] : -1), 64'd2);
    // round-robin alternation
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(1, {4'h1, 32'hA000_0000 + 32'(k)}, 0, 1, {4'h1, 32'hB000_0000 + 32'(k)}, 0, 0);
      tick();
    end
    set_in(0, '0, 0, 0, '0, 0, 0);
    repeat (8) tick();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({4'h1, 32'hA000_0000 + 32'(k)});
      exp_q.push_back({4'h1, 32'hB000_0000 + 32'(k)});
    end
    chk_seq("rr_order");
    chk("rr_span", 64'(got_t.size() == 6 ? got_t[5] - got_t[0] : -1), 64'd5);
    // grant locking keeps A's configuration and pixel commands contiguous
    do_reset();
    set_in(1, 36'hC_1000_0140, 1, 1, 36'h1_B000_0000, 0, 0);
    tick();
    set_in(1, 36'h1_A000_0001, 1, 1, 36'h1_B000_0001, 0, 0);
    tick();
    set_in(1, 36'h1_A000_0002, 1, 0, '0, 0, 0);
    tick();
    set_in(1, 36'h1_A000_0003, 1, 0, '0, 0, 0);
    tick();
    set_in(0, '0, 0, 0, '0, 0, 0);
    repeat (8) tick();
    exp_q.push_back(36'hC_1000_0140);
    exp_q.push_back(36'h1_A000_0001);
    exp_q.push_back(36'h1_A000_0002);
    exp_q.push_back(36'h1_A000_0003);
    exp_q.push_back(36'h1_B000_0000);
    exp_q.push_back(36'h1_B000_0001);
    chk_seq("lock_order");
    // backpressure: output held, FIFO fills, fifth push waits for a pop
    do_reset();
    set_in(1, 36'h1_C000_0000, 0, 0, '0, 0, 0);
    tick();
    set_in(0, '0, 0, 0, '0, 0, 0);
    tick();
    i = 1;
    repeat (5) begin
      set_in(1, {4'h1, 32'hC000_0000 + 32'(i)}, 0, 0, '0, 0, 1);
      if (bus.a_ready) i++;
      tick();
    end
    chk("busy_hold_cmd", 64'(bus.draw_cmd), 64'h1_C000_0000);
    chk("busy_hold_rdy", 64'(bus.draw_cmd_rdy), 64'd1);
    chk("busy_level", 64'(bus.a_level), 64'd4);
    chk("busy_ready", 64'(bus.a_ready), 64'd0);
    for (int n = 0; n < 20 && i <= 5; n++) begin
      set_in(1, {4'h1, 32'hC000_0000 + 32'(i)}, 0, 0, '0, 0, 0);
      if (bus.a_ready) i++;
      tick();
    end
    chk("busy_all_pushed", 64'(i), 64'd6);
    set_in(0, '0, 0, 0, '0, 0, 0);
    repeat (8) tick();
    for (int k = 0; k < 6; k++) exp_q.push_back({4'h1, 32'hC000_0000 + 32'(k)});
    chk_seq("busy_order");
    // NOP is dropped and costs one cycle
    do_reset();
    set_in(1, 36'h0_0000_0000, 0, 0, '0, 0, 0);
    tick();
    set_in(1, 36'h1_2345_6789, 0, 0, '0, 0, 0);
    tick();
    set_in(0, '0, 0, 0, '0, 0, 0);
    repeat (5) tick();
    exp_q.push_back(36'h1_2345_6789);
    chk_seq("nop_drop");
    chk("nop_cycle", 64'(got_t.size() > 0 ? got_t[0] : -1), 64'd3);
    // reset while both FIFOs hold three entries and the output is stalled
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(1, {4'h1, 32'hD000_0000 + 32'(k)}, 0, k < 3, {4'h1, 32'hE000_0000 + 32'(k)}, 0, 1);
      tick();
    end
    chk("pre_rst_a_level", 64'(bus.a_level), 64'd3);
    chk("pre_rst_b_level", 64'(bus.b_level), 64'd3);
    chk("pre_rst_rdy", 64'(bus.draw_cmd_rdy), 64'd1);
    do_reset();
    repeat (6) tick();
    chk("post_rst_none", 64'(got.size()), 64'd0);
    // random traffic with random locks and stalls
    do_reset();
    al = 0;
    bl = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(15) == 0) al = !al;
      if ($urandom_range(15) == 0) bl = !bl;
      set_in($urandom_range(99) < 55,
             {($urandom_range(7) == 0) ? 4'h0 : 4'($urandom_range(15, 1)), 32'($urandom)}, al,
             $urandom_range(99) < 45,
             {($urandom_range(7) == 0) ? 4'h0 : 4'($urandom_range(15, 1)), 32'($urandom)}, bl,
             $urandom_range(99) < 30);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
